amp3_i2s_tx: RTL and testbench

Parametrised I2S/left-justified serial transmitter for the Pmod AMP3. It is the successor to the fixed 12-bit lite interface, with configurable sample width, slot width and bit-clock divider, a ready/valid sample input with a one-deep holding buffer, mono/stereo and justification modes, and an orderly shutdown drain. It sits between an audio source (e.g. the MIC3 capture path) and the AMP3 pins on a Pmod header.

---
 rtl/amp3_i2s_tx.sv | 202 ++++++++++++++++++++
 tb/tb_amp3_i2s_tx.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/amp3_i2s_tx.sv
// Pmod AMP3 I2S / left-justified serial transmitter with a one-deep sample buffer and drain-on-stop.
// Optional build macro AMP3_ATTEN_EN adds a 4-bit arithmetic attenuation input applied at frame load.
module amp3_i2s_tx #(
   parameter int DATA_W  = 12,
   parameter int SLOT_W  = 16,
   parameter int CLK_DIV = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic              mono,
   input  logic              lj_mode,
   input  logic [DATA_W-1:0] sample_l,
   input  logic [DATA_W-1:0] sample_r,
   input  logic              sample_valid,
`ifdef AMP3_ATTEN_EN
   input  logic [3:0]        atten,
`endif
   output logic              sample_ready,
   output logic              frame_start,
   output logic              underrun,
   output logic              BCLK,
   output logic              LRCLK,
   output logic              SDATA,
   output logic              nSHUT
);

   localparam int FRAME_W = 2 * SLOT_W;
   localparam int CNT_W   = $clog2(FRAME_W);
   localparam int DIV_W   = $clog2(CLK_DIV);
   localparam logic [CNT_W-1:0] SLOT_C = CNT_W'(SLOT_W);
   localparam logic [CNT_W-1:0] LAST_C = CNT_W'(FRAME_W - 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t            state_reg;
   logic [DIV_W-1:0]  div_cnt_reg;
   logic [CNT_W-1:0]  bit_cnt_reg;
   logic              bclk_reg;
   logic              lrclk_reg;
   logic              sdata_reg;
   logic              nshut_reg;
   logic              frame_start_reg;
   logic              underrun_reg;
   logic [DATA_W-1:0] hold_l_reg;
   logic [DATA_W-1:0] hold_r_reg;
   logic              hold_full_reg;
   logic [DATA_W-1:0] last_l_reg;
   logic [DATA_W-1:0] last_r_reg;
   logic [DATA_W-1:0] shift_l_reg;
   logic [DATA_W-1:0] shift_r_reg;
   logic              delay_reg;
   logic              lj_reg;

   logic              div_wrap;
   logic              fall_tick;
   logic              frame_wrap;
   logic              start;
   logic              load;
   logic              stop;
   logic              accept;
   logic [CNT_W-1:0]  bit_cnt_next;
   logic [CNT_W-1:0]  pos_cnt;
   logic [CNT_W-1:0]  p_cnt;
   logic              slot_sel;
   logic [DATA_W-1:0] src_l;
   logic [DATA_W-1:0] src_r;
   logic [DATA_W-1:0] scaled_l;
   logic [DATA_W-1:0] scaled_r;
   logic [DATA_W-1:0] load_l;
   logic [DATA_W-1:0] load_r;
   logic [DATA_W-1:0] word;
   logic [DATA_W-1:0] word_sh;
   logic              stream_bit;

   always_comb begin
      div_wrap     = (div_cnt_reg == DIV_LAST);
      fall_tick    = (state_reg != IDLE) && div_wrap && bclk_reg;
      bit_cnt_next = (bit_cnt_reg == LAST_C) ? '0 : bit_cnt_reg + 1'b1;
      frame_wrap   = fall_tick && (bit_cnt_next == '0);
      start        = (state_reg == IDLE) && enable;
      // A DRAIN that sees enable again by the wrap carries on as RUN and loads.
      load         = start || (frame_wrap && ((state_reg == RUN) || enable));
      stop         = frame_wrap && (state_reg == DRAIN) && !enable;
      accept       = sample_valid && !hold_full_reg;

      src_l = hold_full_reg ? hold_l_reg : last_l_reg;
      src_r = hold_full_reg ? hold_r_reg : last_r_reg;
`ifdef AMP3_ATTEN_EN
      scaled_l = $signed(src_l) >>> atten;
      scaled_r = $signed(src_r) >>> atten;
`else
      scaled_l = src_l;
      scaled_r = src_r;
`endif
      load_l = scaled_l;
      load_r = mono ? scaled_l : scaled_r;

      // Stream bit for the position being entered; a load edge must use the new frame.
      pos_cnt  = start ? '0 : bit_cnt_next;
      slot_sel = (pos_cnt >= SLOT_C);
      p_cnt    = slot_sel ? pos_cnt - SLOT_C : pos_cnt;
      if (slot_sel)
         word = load ? load_r : shift_r_reg;
      else
         word = load ? load_l : shift_l_reg;
      // Shifting past DATA_W leaves zeros, which is exactly the slot padding.
      word_sh    = word << p_cnt;
      stream_bit = word_sh[DATA_W-1];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg       <= IDLE;
         div_cnt_reg     <= '0;
         bit_cnt_reg     <= '0;
         bclk_reg        <= 1'b0;
         lrclk_reg       <= 1'b1;
         sdata_reg       <= 1'b0;
         nshut_reg       <= 1'b0;
         frame_start_reg <= 1'b0;
         underrun_reg    <= 1'b0;
         hold_l_reg      <= '0;
         hold_r_reg      <= '0;
         hold_full_reg   <= 1'b0;
         last_l_reg      <= '0;
         last_r_reg      <= '0;
         shift_l_reg     <= '0;
         shift_r_reg     <= '0;
         delay_reg       <= 1'b0;
         lj_reg          <= 1'b0;
      end else begin
         frame_start_reg <= load;
         underrun_reg    <= load && !hold_full_reg;
         hold_full_reg   <= accept || (hold_full_reg && !load);
         if (accept) begin
            hold_l_reg <= sample_l;
            hold_r_reg <= sample_r;
         end
         if (load) begin
            shift_l_reg <= load_l;
            shift_r_reg <= load_r;
            if (hold_full_reg) begin
               last_l_reg <= hold_l_reg;
               last_r_reg <= hold_r_reg;
            end
         end

         case (state_reg)
            IDLE: begin
               if (enable) begin
                  state_reg   <= RUN;
                  nshut_reg   <= 1'b1;
                  bclk_reg    <= 1'b0;
                  div_cnt_reg <= '0;
                  bit_cnt_reg <= '0;
                  lrclk_reg   <= 1'b0;
                  lj_reg      <= lj_mode;
                  sdata_reg   <= lj_mode ? stream_bit : delay_reg;
                  delay_reg   <= stream_bit;
               end
            end
            default: begin
               if (div_wrap) begin
                  div_cnt_reg <= '0;
                  bclk_reg    <= ~bclk_reg;
               end else begin
                  div_cnt_reg <= div_cnt_reg + 1'b1;
               end
               if (stop) begin
                  state_reg   <= IDLE;
                  div_cnt_reg <= '0;
                  bit_cnt_reg <= '0;
                  bclk_reg    <= 1'b0;
                  lrclk_reg   <= 1'b1;
                  sdata_reg   <= 1'b0;
                  nshut_reg   <= 1'b0;
                  delay_reg   <= 1'b0;
               end else begin
                  state_reg <= enable ? RUN : DRAIN;
                  if (fall_tick) begin
                     bit_cnt_reg <= bit_cnt_next;
                     lrclk_reg   <= slot_sel;
                     sdata_reg   <= lj_reg ? stream_bit : delay_reg;
                     delay_reg   <= stream_bit;
                  end
               end
            end
         endcase
      end
   end

   assign sample_ready = !hold_full_reg;
   assign frame_start  = frame_start_reg;
   assign underrun     = underrun_reg;
   assign BCLK         = bclk_reg;
   assign LRCLK        = lrclk_reg;
   assign SDATA        = sdata_reg;
   assign nSHUT        = nshut_reg;

endmodule

// File: tb/tb_amp3_i2s_tx.sv
// Directed bench for amp3_i2s_tx at default parameters: whole frames are captured bit by bit
// and compared against hand-derived slot patterns.
module tb_amp3_i2s_tx;
   localparam int DATA_W  = 12;
   localparam int SLOT_W  = 16;
   localparam int CLK_DIV = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              enable;
   logic              mono;
   logic              lj_mode;
   logic [DATA_W-1:0] sample_l;
   logic [DATA_W-1:0] sample_r;
   logic              sample_valid;
   logic              sample_ready;
   logic              frame_start;
   logic              underrun;
   logic              BCLK;
   logic              LRCLK;
   logic              SDATA;
   logic              nSHUT;
`ifdef AMP3_ATTEN_EN
   logic [3:0]        atten = 4'd0;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   amp3_i2s_tx #(.DATA_W(DATA_W), .SLOT_W(SLOT_W), .CLK_DIV(CLK_DIV)) dut (
      .clk(clk),
      .rst(rst),
      .enable(enable),
      .mono(mono),
      .lj_mode(lj_mode),
      .sample_l(sample_l),
      .sample_r(sample_r),
      .sample_valid(sample_valid),
`ifdef AMP3_ATTEN_EN
      .atten(atten),
`endif
      .sample_ready(sample_ready),
      .frame_start(frame_start),
      .underrun(underrun),
      .BCLK(BCLK),
      .LRCLK(LRCLK),
      .SDATA(SDATA),
      .nSHUT(nSHUT)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      enable = 1'b0;
      sample_valid = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic offer(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r);
      sample_l = l;
      sample_r = r;
      sample_valid = 1'b1;
      tick();
      sample_valid = 1'b0;
   endtask

   // Check the load-edge pulses and buffer state right after a frame load edge.
   task automatic check_load(input string name, input logic exp_fs, input logic exp_ur, input logic exp_rdy);
      checks++;
      if ({frame_start, underrun, sample_ready} !== {exp_fs, exp_ur, exp_rdy}) begin
         errors++;
         $display("FAIL %s load fs/ur/rdy got %b%b%b want %b%b%b", name,
                  frame_start, underrun, sample_ready, exp_fs, exp_ur, exp_rdy);
      end
   endtask

   // Called just after a load edge; walks 255 further cycles and leaves the next load edge to the caller.
   task automatic capture_frame(input string name, input logic [31:0] exp_sd, input int drop_pos);
      logic [31:0]  sd;
      logic [31:0]  lr;
      logic [255:0] bc;
      int           pulses;
      sd = '0;
      lr = '0;
      bc = '0;
      pulses = 0;
      for (int t = 0; t < 256; t++) begin
         if (t > 0) begin
            tick();
            if (frame_start === 1'b1 || underrun === 1'b1) pulses++;
         end
         if (t % 8 == 0) begin
            sd[31 - t/8] = SDATA;
            lr[31 - t/8] = LRCLK;
            if (t/8 == drop_pos) enable = 1'b0;
         end
         bc[255 - t] = BCLK;
      end
      checks++;
      if (sd !== exp_sd) begin
         errors++;
         $display("FAIL %s sdata got %h want %h", name, sd, exp_sd);
      end
      checks++;
      if (lr !== 32'h0000FFFF) begin
         errors++;
         $display("FAIL %s lrclk got %h want 0000ffff", name, lr);
      end
      checks++;
      if (bc !== {32{8'h0F}}) begin
         errors++;
         $display("FAIL %s bclk got %h want %h", name, bc, {32{8'h0F}});
      end
      checks++;
      if (pulses != 0) begin
         errors++;
         $display("FAIL %s stray pulses got %0d want 0", name, pulses);
      end
   endtask

   task automatic stop_run(input string name);
      int n;
      enable = 1'b0;
      n = 0;
      while (nSHUT === 1'b1 && n < 600) begin
         tick();
         n++;
      end
      checks++;
      if (nSHUT !== 1'b0) begin
         errors++;
         $display("FAIL %s shutdown nSHUT got %b want 0 within 600 cycles", name, nSHUT);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      enable = 1'b1;
      sample_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if ({BCLK, LRCLK, SDATA, nSHUT, sample_ready, frame_start, underrun} !== 7'b0100100) begin
            errors++;
            $display("FAIL reset cycle %0d outputs got %b want 0100100", i,
                     {BCLK, LRCLK, SDATA, nSHUT, sample_ready, frame_start, underrun});
         end
      end
      enable = 1'b0;
      tick();
      rst = 1'b0;
      $display("test_reset done");
   endtask

   // Left-justified run including a sample offered on the load edge and a pure underrun.
   task automatic test_lj();
      do_reset();
      lj_mode = 1'b1;
      mono = 1'b0;
      offer(12'hA5C, 12'h3F0);
      checks++;
      if (sample_ready !== 1'b0) begin
         errors++;
         $display("FAIL lj accept sample_ready got %b want 0", sample_ready);
      end
      enable = 1'b1;
      tick();
      checks++;
      if ({nSHUT, LRCLK, BCLK} !== 3'b100) begin
         errors++;
         $display("FAIL lj entry nSHUT/LRCLK/BCLK got %b want 100", {nSHUT, LRCLK, BCLK});
      end
      check_load("lj_entry", 1'b1, 1'b0, 1'b1);
      capture_frame("lj_frame1", 32'hA5C03F00, -1);
      offer(12'h123, 12'hFED);
      check_load("lj_coincide", 1'b1, 1'b1, 1'b0);
      capture_frame("lj_frame2", 32'hA5C03F00, -1);
      tick();
      check_load("lj_newpair", 1'b1, 1'b0, 1'b1);
      capture_frame("lj_frame3", 32'h1230FED0, -1);
      tick();
      check_load("lj_underrun", 1'b1, 1'b1, 1'b1);
      capture_frame("lj_frame4", 32'h1230FED0, -1);
      stop_run("lj");
      $display("test_lj done");
   endtask

   // I2S run; lj_mode is flipped mid-run and must be ignored until the next start.
   task automatic test_i2s();
      do_reset();
      lj_mode = 1'b0;
      mono = 1'b0;
      offer(12'hA5C, 12'h3F0);
      enable = 1'b1;
      tick();
      check_load("i2s_entry", 1'b1, 1'b0, 1'b1);
      lj_mode = 1'b1;
      capture_frame("i2s_frame1", 32'h52E01F80, -1);
      tick();
      check_load("i2s_underrun", 1'b1, 1'b1, 1'b1);
      capture_frame("i2s_frame2", 32'h52E01F80, -1);
      stop_run("i2s");
      lj_mode = 1'b1;
      $display("test_i2s done");
   endtask

   task automatic test_mono();
      do_reset();
      lj_mode = 1'b1;
      mono = 1'b1;
      offer(12'h800, 12'h7FF);
      enable = 1'b1;
      tick();
      check_load("mono_entry", 1'b1, 1'b0, 1'b1);
      capture_frame("mono_frame", 32'h80008000, -1);
      stop_run("mono");
      mono = 1'b0;
      $display("test_mono done");
   endtask

   task automatic test_drain();
      logic still_idle;
      do_reset();
      lj_mode = 1'b1;
      mono = 1'b0;
      offer(12'hA5C, 12'h3F0);
      enable = 1'b1;
      tick();
      capture_frame("drain_frame", 32'hA5C03F00, 5);
      checks++;
      if (nSHUT !== 1'b1) begin
         errors++;
         $display("FAIL drain before wrap nSHUT got %b want 1", nSHUT);
      end
      tick();
      checks++;
      if ({BCLK, LRCLK, SDATA, nSHUT, sample_ready, frame_start, underrun} !== 7'b0100100) begin
         errors++;
         $display("FAIL drain wrap outputs got %b want 0100100",
                  {BCLK, LRCLK, SDATA, nSHUT, sample_ready, frame_start, underrun});
      end
      still_idle = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (BCLK !== 1'b0 || nSHUT !== 1'b0 || frame_start !== 1'b0) still_idle = 1'b0;
      end
      checks++;
      if (still_idle !== 1'b1) begin
         errors++;
         $display("FAIL drain idle hold got %b want 1", still_idle);
      end
      $display("test_drain done");
   endtask

   initial begin
      rst = 1'b1;
      enable = 1'b0;
      mono = 1'b0;
      lj_mode = 1'b1;
      sample_valid = 1'b0;
      sample_l = '0;
      sample_r = '0;
      test_reset();
      test_lj();
      test_i2s();
      test_mono();
      test_drain();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
